// File: rtl/led_scan_pen.sv
// Raster scanner for the 8x8 LED matrix with a light-pen sampler.
// Each pixel slot ends in a flash window; enough pen samples there trigger a 2+2 cycle write handshake.
module led_scan_pen #(
    parameter int DWELL_CYCLES = 64,
    parameter int PEN_WIN      = 8,
    parameter int PEN_HITS     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       pen_in,
    input  logic [3:0] led_data,
    output logic [7:0] addr_row,
    output logic [7:0] addr_col,
    output logic       we,
    output logic       pix_on,
    output logic       frame_start
);

    localparam int DW = $clog2(DWELL_CYCLES);
    localparam int HW = $clog2(PEN_WIN + 1);

    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
    localparam logic [DW-1:0] WIN_START  = DW'(DWELL_CYCLES - PEN_WIN);
    localparam logic [HW-1:0] HIT_SAT    = HW'(PEN_WIN);
    localparam logic [HW:0]   HIT_NEED   = (HW+1)'(PEN_HITS);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SCAN  = 2'd1;
    localparam logic [1:0] S_WE_HI = 2'd2;
    localparam logic [1:0] S_WE_LO = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [2:0]    row_q, row_d;
    logic [2:0]    col_q, col_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [HW-1:0] hit_q, hit_d;
    logic          hs_q, hs_d;
    logic          pen_meta_q, pen_s_q;
    logic [7:0]    addr_row_q, addr_col_q;
    logic [7:0]    row_hot, col_hot;
    logic          we_q, we_d;
    logic          pix_q, pix_d;
    logic          fs_q, fs_d;
    logic          advance;
    logic [HW:0]   hit_sum;
    logic          hit_found;

    assign hit_sum   = {1'b0, hit_q} + {{HW{1'b0}}, pen_s_q};
    assign hit_found = (hit_sum >= HIT_NEED);

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        dwell_d = dwell_q;
        hit_d   = hit_q;
        hs_d    = hs_q;
        we_d    = 1'b0;
        pix_d   = 1'b0;
        fs_d    = 1'b0;
        advance = 1'b0;

        case (state_q)
            S_IDLE: begin
                row_d   = 3'd0;
                col_d   = 3'd0;
                dwell_d = '0;
                hit_d   = '0;
                hs_d    = 1'b0;
                if (en) begin
                    state_d = S_SCAN;
                    fs_d    = 1'b1;
                end
            end
            S_SCAN: begin
                if (dwell_q == '0) begin
                    pix_d = 1'b0;
                end else if (dwell_q < WIN_START) begin
                    pix_d = (led_data > dwell_q[3:0]);
                end else begin
                    pix_d = 1'b1;
                    if (hit_q != HIT_SAT) begin
                        hit_d = hit_q + {{(HW-1){1'b0}}, pen_s_q};
                    end
                end
                if (dwell_q == DWELL_LAST) begin
                    // A hit dims the pixel and holds the address for the write handshake
                    if (hit_found) begin
                        state_d = S_WE_HI;
                        we_d    = 1'b1;
                        pix_d   = 1'b0;
                        hs_d    = 1'b0;
                    end else begin
                        advance = 1'b1;
                    end
                end else begin
                    dwell_d = dwell_q + DW'(1);
                end
            end
            S_WE_HI: begin
                if (hs_q == 1'b0) begin
                    we_d = 1'b1;
                    hs_d = 1'b1;
                end else begin
                    state_d = S_WE_LO;
                    hs_d    = 1'b0;
                end
            end
            default: begin
                if (hs_q == 1'b0) begin
                    hs_d = 1'b1;
                end else begin
                    hs_d    = 1'b0;
                    advance = 1'b1;
                end
            end
        endcase

        if (advance) begin
            dwell_d = '0;
            hit_d   = '0;
            if (!en) begin
                state_d = S_IDLE;
                row_d   = 3'd0;
                col_d   = 3'd0;
            end else begin
                state_d = S_SCAN;
                col_d   = col_q + 3'd1;
                if (col_q == 3'd7) begin
                    row_d = row_q + 3'd1;
                end
                fs_d = (row_q == 3'd7) && (col_q == 3'd7);
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_onehot
            assign row_hot[gi] = (row_d == 3'(gi));
            assign col_hot[gi] = (col_d == 3'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            row_q      <= 3'd0;
            col_q      <= 3'd0;
            dwell_q    <= '0;
            hit_q      <= '0;
            hs_q       <= 1'b0;
            pen_meta_q <= 1'b0;
            pen_s_q    <= 1'b0;
            addr_row_q <= 8'h01;
            addr_col_q <= 8'h01;
            we_q       <= 1'b0;
            pix_q      <= 1'b0;
            fs_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            dwell_q    <= dwell_d;
            hit_q      <= hit_d;
            hs_q       <= hs_d;
            pen_meta_q <= pen_in;
            pen_s_q    <= pen_meta_q;
            addr_row_q <= row_hot;
            addr_col_q <= col_hot;
            we_q       <= we_d;
            pix_q      <= pix_d;
            fs_q       <= fs_d;
        end
    end

    assign addr_row    = addr_row_q;
    assign addr_col    = addr_col_q;
    assign we          = we_q;
    assign pix_on      = pix_q;
    assign frame_start = fs_q;

endmodule
